// File: rtl/count_bcd_conv_pkg.sv
// count_bcd_pkg: shared state type, digit width and DIGITS sizing helper for the BCD converter
package count_bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam int BCD_DIGIT_W = 4;
  function automatic int digits_needed(input int width);
    longint unsigned lim = 64'd10;
    int d = 1;
    for (int i = 0; i < 19; i++)
      if (lim <= (64'd1 << width) - 64'd1) begin
        lim = lim * 64'd10;
        d++;
      end
    return d;
  endfunction
endpackage

// File: rtl/count_bcd_conv_if.sv
// count_bcd_conv_if: request/result bundle between the counter side and the BCD converter
interface count_bcd_conv_if #(
  parameter int WIDTH = 8,
  parameter int DIGITS = 3
);
  logic start;
  logic sgn;
  logic [WIDTH-1:0] bin;
  logic busy;
  logic done;
  logic [4*DIGITS-1:0] bcd;
  logic neg;
  modport master(output start, sgn, bin, input busy, done, bcd, neg);
  modport slave(input start, sgn, bin, output busy, done, bcd, neg);
endinterface

// File: rtl/count_bcd_conv_digit_adj.sv
// bcd_digit_adj: double-dabble correction cell, adds 3 to a BCD digit of 5 or more
module bcd_digit_adj
  import count_bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] d_o
);
  assign d_o = (d_i >= BCD_DIGIT_W'(5)) ? d_i + BCD_DIGIT_W'(3) : d_i;
endmodule

// File: rtl/count_bcd_conv.sv
// count_bcd_conv: one-bit-per-clock shift-and-add-3 binary-to-BCD converter with optional signed input
module count_bcd_conv
  import count_bcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGITS = 3
) (
  input logic clk,
  input logic rst,
  count_bcd_conv_if.slave bus
);
  localparam int SW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  if (DIGITS < digits_needed(WIDTH)) begin : g_bad_digits
    $error("count_bcd_conv: DIGITS too small to hold 2**WIDTH-1");
  end
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] op_q, op_d, mag;
  logic [SW-1:0] scr_q, scr_d, scr_adj, bcd_q, bcd_d;
  logic [SW+WIDTH-1:0] sh;
  logic sign_q, sign_d, neg_q, neg_d, neg_in, accept;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i(scr_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_o(scr_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end
  // negating the most negative value yields its true magnitude when read as unsigned
  assign neg_in = bus.sgn & bus.bin[WIDTH-1];
  assign mag = neg_in ? -bus.bin : bus.bin;
  assign accept = bus.start & (state_q != SHIFT);
  assign sh = {scr_adj[SW-2:0], op_q, 1'b0};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    scr_d = scr_q;
    sign_d = sign_q;
    bcd_d = bcd_q;
    neg_d = neg_q;
    if (accept) begin
      state_d = SHIFT;
      cnt_d = CW'(WIDTH);
      op_d = mag;
      scr_d = '0;
      sign_d = neg_in;
    end else if (state_q == SHIFT) begin
      scr_d = sh[SW+WIDTH-1:WIDTH];
      op_d = sh[WIDTH-1:0];
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        state_d = DONE;
        bcd_d = sh[SW+WIDTH-1:WIDTH];
        neg_d = sign_q;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // results load on the final shift edge so they are already valid during the done cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      scr_q <= '0;
      sign_q <= 1'b0;
      bcd_q <= '0;
      neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      scr_q <= scr_d;
      sign_q <= sign_d;
      bcd_q <= bcd_d;
      neg_q <= neg_d;
    end
  assign bus.busy = state_q == SHIFT;
  assign bus.done = state_q == DONE;
  assign bus.bcd = bcd_q;
  assign bus.neg = neg_q;
endmodule

// File: tb/tb_count_bcd_conv.sv
// tb_count_bcd_conv: random and directed stimulus against a decimal-arithmetic reference model
module tb_count_bcd_conv;
  localparam int W = 8;
  localparam int D = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  count_bcd_conv_if #(.WIDTH(W), .DIGITS(D)) bus ();
  count_bcd_conv #(.WIDTH(W), .DIGITS(D)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  function automatic logic [4*D:0] ref_conv(input logic s, input logic [W-1:0] b);
    int v = s ? int'($signed(b)) : int'(b);
    int m = (v < 0) ? -v : v;
    logic [4*D:0] r = '0;
    r[4*D] = v < 0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction
  // cycles remaining until done (done when 1), plus the pending and visible {neg,bcd}
  int left = 0;
  logic [4*D:0] exp_pend = '0;
  logic [4*D:0] exp_out = '0;
  always @(posedge clk or posedge rst)
    if (rst) begin
      left = 0;
      exp_out = '0;
    end else if (left <= 1 && bus.start) begin
      left = W + 1;
      exp_pend = ref_conv(bus.sgn, bus.bin);
    end else if (left > 0) begin
      left--;
      if (left == 1) exp_out = exp_pend;
    end
  always @(negedge clk) begin
    check("busy", 32'(bus.busy), 32'(left >= 2));
    check("done", 32'(bus.done), 32'(left == 1));
    check("result", 32'({bus.neg, bus.bcd}), 32'(exp_out));
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 20);
  endtask
  task automatic conv(input string tag, input logic s, input logic [W-1:0] b, input logic [4*D:0] exp);
    int n;
    bus.start = 1'b1;
    bus.sgn = s;
    bus.bin = b;
    tick();
    bus.start = 1'b0;
    bus.sgn = 1'($urandom);
    bus.bin = W'($urandom);
    wait_done(n);
    check({tag, "_lat"}, 32'(n), 32'(W + 1));
    check(tag, 32'({bus.neg, bus.bcd}), 32'(exp));
    tick();
  endtask
  initial begin
    int n;
    logic [W-1:0] cnt;
    bus.start = 1'b0;
    bus.sgn = 1'b0;
    bus.bin = '0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_state", 32'({bus.busy, bus.done, bus.neg, bus.bcd}), 32'(0));
    tick();
    conv("u_ff", 1'b0, 8'hFF, 13'h0255);
    conv("u_00", 1'b0, 8'h00, 13'h0000);
    conv("s_80", 1'b1, 8'h80, 13'h1128);
    conv("s_ff", 1'b1, 8'hFF, 13'h1001);
    conv("s_7f", 1'b1, 8'h7F, 13'h0127);
    conv("s_00", 1'b1, 8'h00, 13'h0000);
    conv("u_07", 1'b0, 8'h07, 13'h0007);
    bus.start = 1'b1;
    bus.sgn = 1'b0;
    bus.bin = 8'h2A;
    tick();
    bus.start = 1'b0;
    repeat (2) tick();
    bus.start = 1'b1;
    bus.bin = 8'h63;
    tick();
    bus.start = 1'b0;
    wait_done(n);
    check("busy_ign", 32'({bus.neg, bus.bcd}), 32'(13'h0042));
    repeat (12) tick();
    bus.start = 1'b1;
    bus.bin = 8'd10;
    tick();
    bus.bin = 8'd99;
    repeat (W + 1) tick();
    bus.start = 1'b0;
    repeat (12) tick();
    bus.start = 1'b1;
    bus.bin = 8'hC8;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("rst_mid", 32'({bus.busy, bus.done, bus.neg, bus.bcd}), 32'(0));
    tick();
    rst = 1'b0;
    repeat (12) tick();
    conv("u_c8", 1'b0, 8'hC8, 13'h0200);
    cnt = 8'hFE;
    bus.sgn = 1'b0;
    for (int k = 0; k < 6 * (W + 1); k++) begin
      bus.bin = cnt;
      bus.start = (k % (W + 1)) == 0;
      tick();
      if (bus.start) cnt++;
    end
    bus.start = 1'b0;
    repeat (12) tick();
    for (int k = 0; k < 600; k++) begin
      bus.start = $urandom_range(2) == 0;
      bus.sgn = 1'($urandom);
      bus.bin = W'($urandom);
      rst = $urandom_range(150) == 0;
      tick();
      rst = 1'b0;
    end
    bus.start = 1'b0;
    repeat (12) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/count_bcd_conv.md
# count_bcd_conv

Sequential binary-to-BCD converter that sits directly downstream of the 8-bit up/down counter. It samples the counter's `count` value on request and produces packed BCD digits for the display/readout stage. Conversion uses shift-and-add-3 (double dabble), one bit per clock. An optional signed mode treats the input as two's complement and returns a magnitude plus a sign flag.

## Interface
Parameters:
- `WIDTH`, default 8: binary input width.
- `DIGITS`, default 3: number of BCD output digits.
  - Must satisfy 10^DIGITS > 2^WIDTH − 1.
  - Elaboration fails if this does not hold.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: conversion request; sampled only when accepting (IDLE or DONE).
- `sgn`  in  1: sampled with `start`. 1 means `bin` is two's complement; 0 means unsigned.
- `bin`  in  WIDTH: value to convert, normally the counter's `count`; sampled with `start`.
- `busy`  out  1: high while a conversion is in progress.
- `done`  out  1: one-cycle pulse; `bcd` and `neg` are valid and newly updated.
- `bcd`  out  4*DIGITS: packed BCD. Digit 0 (units) is in bits [3:0]. Holds its value until the next `done`.
- `neg`  out  1: result is negative (signed mode only). Holds with `bcd`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: `start`=1 → capture the operand, clear the scratch BCD register, load bit counter = WIDTH, go to SHIFT.
  - SHIFT, each cycle:
    - Every scratch digit ≥5 gets +3.
    - Then shift {scratch, operand} left by one.
    - Decrement the bit counter.
    - When the counter reaches 0 after this update, go to DONE.
  - DONE: copy scratch → `bcd` and latched sign → `neg`; assert `done` for this cycle.
    - `start`=1 here → accept a new conversion exactly as in IDLE and go to SHIFT.
    - Otherwise go to IDLE.
- `start` in SHIFT is ignored. There is no queuing and no error flag.
- Operand capture:
  - `sgn`=0: operand = `bin`, latched sign = 0.
  - `sgn`=1 and `bin`[WIDTH−1]=1: operand = two's-complement negation of `bin`, as a WIDTH-bit unsigned value; latched sign = 1.
  - Most negative value (0x80 for WIDTH=8) converts to magnitude 128 and must not wrap.
  - `sgn`=1 and `bin`=0: `neg`=0.
- Output width rules:
  - Scratch register is 4*DIGITS bits.
  - Digits above the value's most significant digit read 0 (e.g. 7 → 0x007).
- Outputs change only in DONE. `bcd` and `neg` never show intermediate scratch values.
- Reset values: state IDLE, `busy`=0, `done`=0, `bcd`=0, `neg`=0, scratch and bit counter 0.
- Reset mid-conversion aborts immediately:
  - No `done` is produced.
  - `bcd` and `neg` return to 0.
  - The next `start` after reset deassertion is accepted normally.

## Timing
- Request accepted on edge N (`start`=1 in IDLE or DONE).
- `busy`=1 during cycles N+1 … N+WIDTH, i.e. all SHIFT cycles.
- `done`=1 in cycle N+WIDTH+1; `busy`=0 in DONE.
- `bcd` and `neg` take their new values at the start of that same cycle.
- Latency from `start` to `done`: WIDTH+1 cycles (9 for defaults).
- Maximum throughput: one conversion per WIDTH+1 cycles, with `start` held or re-asserted during DONE.
- `bin` and `sgn` need to be stable only at the accepting edge. The counter may keep counting afterwards without affecting the result.

## Structure
- Package `count_bcd_pkg` holds:
  - the state enum (IDLE/SHIFT/DONE);
  - `BCD_DIGIT_W` = 4;
  - a constant function `digits_needed(width)` used for the DIGITS elaboration check.
- Sub-module `bcd_digit_adj`: a 4-bit combinational add-3-if-≥5 cell, instantiated DIGITS times in a generate loop.
- Top level holds the FSM, bit counter, operand/scratch shift register, sign latch and output registers.

## Test plan
- Unsigned boundaries:
  - `sgn`=0, `bin`=0xFF, `start` pulse → `done` 9 cycles later, `bcd`=0x255, `neg`=0.
  - `bin`=0x00 → `bcd`=0x000.
- Signed values:
  - `sgn`=1, `bin`=0x80 → `bcd`=0x128, `neg`=1.
  - `bin`=0xFF → `bcd`=0x001, `neg`=1.
  - `bin`=0x7F → `bcd`=0x127, `neg`=0.
- Start while busy: `bin`=0x2A, then `start`=1 with `bin`=0x63 three cycles later → single `done` with `bcd`=0x042. The second request is ignored.
- Back-to-back: `start` held high continuously with `bin` = 10, then 99 → `done` pulses 9 cycles apart, `bcd`=0x010 then 0x099, `busy` low only in the DONE cycles.
- Reset mid-operation: `rst` asserted 4 cycles into converting 0xC8 → `busy`, `done`, `bcd` and `neg` all 0 at once, no `done` afterwards. A new `start` with 0xC8 → `bcd`=0x200.
- Counter hookup: drive `bin` from the up/down counter (load 0xFE, count up) and pulse `start` every 9 cycles → every `bcd` equals the decimal value of the count at the accepting edge, including the 0xFF→0x00 wrap (0x255 then 0x000).
